// File: rtl/fare_coin_collector.sv
// Fare/coin front end: latches a ticket selection, prices it, collects coins and hands a
// {destination, quantity, cost, paid} bundle to change_processing, or refunds on cancel/timeout.
module fare_coin_collector #(
  parameter int unsigned FARE1   = 3,
  parameter int unsigned FARE2   = 6,
  parameter int unsigned FARE3   = 5,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic       CLK,
  input  logic       RD,
  input  logic       SEL_VALID,
  input  logic [1:0] DEST_SEL,
  input  logic [1:0] QUA_SEL,
  input  logic       COIN_VALID,
  input  logic [3:0] COIN_VAL,
  input  logic       CANCEL,
  output logic       SEL_REJECT,
  output logic       COIN_REJECT,
  output logic [1:0] DESTINATION_OUT,
  output logic [1:0] QUA_OUT,
  output logic [3:0] COST_OUT,
  output logic [3:0] COIN_OUT,
  output logic       FINISH,
  output logic [3:0] REFUND,
  output logic       REFUND_VALID,
  output logic       BUSY
);

  localparam int unsigned CntW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StPay, StDone, StRefund} state_e;

  state_e          state_q, state_d;
  logic [1:0]      dest_q, dest_d;
  logic [1:0]      qua_q, qua_d;
  logic [3:0]      cost_q, cost_d;
  logic [3:0]      coin_q, coin_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            sel_rej_q, sel_rej_d;
  logic            coin_rej_q, coin_rej_d;
  logic            finish_q, finish_d;
  logic [3:0]      refund_q, refund_d;
  logic            refund_valid_q, refund_valid_d;
  logic            busy_q, busy_d;

  logic [5:0] fare6;
  logic [5:0] cost6;
  logic       sel_ok;
  logic [4:0] sum5;
  logic       coin_ok;

  // Pricing is done at 6 bits so a 3-ticket order of the dearest fare is seen as overflow.
  always_comb begin
    case (DEST_SEL)
      2'b01:   fare6 = 6'(FARE1);
      2'b10:   fare6 = 6'(FARE2);
      2'b11:   fare6 = 6'(FARE3);
      default: fare6 = 6'd0;
    endcase
    cost6  = fare6 * {4'b0000, QUA_SEL};
    sel_ok = (DEST_SEL != 2'b00) && (QUA_SEL != 2'b00) && (cost6 <= 6'd15);
  end

  assign sum5    = {1'b0, coin_q} + {1'b0, COIN_VAL};
  assign coin_ok = (COIN_VAL != 4'd0) && (sum5 <= 5'd15);

  always_comb begin
    state_d    = state_q;
    dest_d     = dest_q;
    qua_d      = qua_q;
    cost_d     = cost_q;
    coin_d     = coin_q;
    cnt_d      = cnt_q;
    sel_rej_d  = 1'b0;
    coin_rej_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        coin_rej_d = COIN_VALID;
        if (SEL_VALID) begin
          if (sel_ok) begin
            dest_d  = DEST_SEL;
            qua_d   = QUA_SEL;
            cost_d  = cost6[3:0];
            coin_d  = 4'd0;
            cnt_d   = '0;
            state_d = StPay;
          end else begin
            sel_rej_d = 1'b1;
          end
        end
      end
      StPay: begin
        if (CANCEL) begin
          // Cancel wins over a coin presented in the same cycle.
          coin_rej_d = COIN_VALID;
          state_d    = StRefund;
        end else if (COIN_VALID && coin_ok) begin
          coin_d = sum5[3:0];
          cnt_d  = '0;
          if (sum5 >= {1'b0, cost_q}) begin
            state_d = StDone;
          end
        end else begin
          coin_rej_d = COIN_VALID;
          if (cnt_q == CntMax) begin
            state_d = StRefund;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StDone: begin
        coin_rej_d = COIN_VALID;
        state_d    = StIdle;
      end
      StRefund: begin
        coin_rej_d = COIN_VALID;
        dest_d     = 2'd0;
        qua_d      = 2'd0;
        cost_d     = 4'd0;
        coin_d     = 4'd0;
        cnt_d      = '0;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Pulse outputs are registered against the state being entered.
    finish_d       = (state_d == StDone);
    refund_valid_d = (state_d == StRefund);
    refund_d       = (state_d == StRefund) ? coin_d : 4'd0;
    busy_d         = (state_d != StIdle);
  end

  always_ff @(posedge CLK or negedge RD) begin
    if (!RD) begin
      state_q        <= StIdle;
      dest_q         <= 2'd0;
      qua_q          <= 2'd0;
      cost_q         <= 4'd0;
      coin_q         <= 4'd0;
      cnt_q          <= '0;
      sel_rej_q      <= 1'b0;
      coin_rej_q     <= 1'b0;
      finish_q       <= 1'b0;
      refund_q       <= 4'd0;
      refund_valid_q <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      dest_q         <= dest_d;
      qua_q          <= qua_d;
      cost_q         <= cost_d;
      coin_q         <= coin_d;
      cnt_q          <= cnt_d;
      sel_rej_q      <= sel_rej_d;
      coin_rej_q     <= coin_rej_d;
      finish_q       <= finish_d;
      refund_q       <= refund_d;
      refund_valid_q <= refund_valid_d;
      busy_q         <= busy_d;
    end
  end

  assign SEL_REJECT      = sel_rej_q;
  assign COIN_REJECT     = coin_rej_q;
  assign DESTINATION_OUT = dest_q;
  assign QUA_OUT         = qua_q;
  assign COST_OUT        = cost_q;
  assign COIN_OUT        = coin_q;
  assign FINISH          = finish_q;
  assign REFUND          = refund_q;
  assign REFUND_VALID    = refund_valid_q;
  assign BUSY            = busy_q;

endmodule

// File: tb/tb_fare_coin_collector.sv
// Scoreboard bench for fare_coin_collector: a transaction-level model predicts pulses and
// status per cycle; a monitor pops and compares them against the DUT.
module tb_fare_coin_collector;

  localparam int unsigned TO = 8;

  logic       CLK = 1'b0;
  logic       RD = 1'b0;
  logic       SEL_VALID = 1'b0;
  logic [1:0] DEST_SEL = 2'd0;
  logic [1:0] QUA_SEL = 2'd0;
  logic       COIN_VALID = 1'b0;
  logic [3:0] COIN_VAL = 4'd0;
  logic       CANCEL = 1'b0;
  logic       SEL_REJECT, COIN_REJECT, FINISH, REFUND_VALID, BUSY;
  logic [1:0] DESTINATION_OUT, QUA_OUT;
  logic [3:0] COST_OUT, COIN_OUT, REFUND;

  fare_coin_collector #(
    .FARE1  (3),
    .FARE2  (6),
    .FARE3  (5),
    .TIMEOUT(TO)
  ) dut (
    .CLK            (CLK),
    .RD             (RD),
    .SEL_VALID      (SEL_VALID),
    .DEST_SEL       (DEST_SEL),
    .QUA_SEL        (QUA_SEL),
    .COIN_VALID     (COIN_VALID),
    .COIN_VAL       (COIN_VAL),
    .CANCEL         (CANCEL),
    .SEL_REJECT     (SEL_REJECT),
    .COIN_REJECT    (COIN_REJECT),
    .DESTINATION_OUT(DESTINATION_OUT),
    .QUA_OUT        (QUA_OUT),
    .COST_OUT       (COST_OUT),
    .COIN_OUT       (COIN_OUT),
    .FINISH         (FINISH),
    .REFUND         (REFUND),
    .REFUND_VALID   (REFUND_VALID),
    .BUSY           (BUSY)
  );

  always #5 CLK = ~CLK;

  // Event kinds: 0 sel reject, 1 coin reject, 2 finish, 3 refund.
  typedef struct {int kind; int dest; int qua; int cost; int coin; int refund;} ev_t;
  typedef struct {int busy; int dest; int qua; int cost; int coin; int refund;} st_t;

  ev_t evq[$];
  st_t stq[$];
  int  n_tests = 0;
  int  n_fail = 0;
  bit  started = 1'b0;
  bit  rd_drv = 1'b0;

  // Reference model: the ticket being bought, what has been paid, and how long it sat idle.
  int m_phase = 0;  // 0 idle, 1 paying, 2 done, 3 refunding
  int m_dest = 0, m_qua = 0, m_cost = 0, m_paid = 0, m_idle = 0;

  function automatic int fare(input int d);
    case (d)
      1: return 3;
      2: return 6;
      3: return 5;
      default: return 0;
    endcase
  endfunction

  task automatic push_ev(input int k);
    ev_t e;
    e.kind = k; e.dest = m_dest; e.qua = m_qua; e.cost = m_cost; e.coin = m_paid;
    e.refund = m_paid;
    evq.push_back(e);
  endtask

  task automatic model_step(input bit rst_n, input bit sel, input int dest, input int qua,
                            input bit coin, input int val, input bit cancel);
    bit  srej, crej;
    int  c;
    st_t s;
    srej = 1'b0;
    crej = 1'b0;
    if (!rst_n) begin
      m_phase = 0; m_dest = 0; m_qua = 0; m_cost = 0; m_paid = 0; m_idle = 0;
    end else begin
      case (m_phase)
        0: begin
          crej = coin;
          if (sel) begin
            c = fare(dest) * qua;
            if (dest == 0 || qua == 0 || c > 15) srej = 1'b1;
            else begin
              m_dest = dest; m_qua = qua; m_cost = c; m_paid = 0; m_idle = 0; m_phase = 1;
            end
          end
        end
        1: begin
          if (cancel) begin
            crej = coin;
            m_phase = 3;
          end else if (coin && val != 0 && m_paid + val <= 15) begin
            m_paid += val;
            m_idle = 0;
            if (m_paid >= m_cost) m_phase = 2;
          end else begin
            crej = coin;
            m_idle++;
            if (m_idle == TO) m_phase = 3;
          end
        end
        2: begin
          crej = coin;
          m_phase = 0;
        end
        default: begin
          crej = coin;
          m_dest = 0; m_qua = 0; m_cost = 0; m_paid = 0; m_phase = 0;
        end
      endcase
      if (srej) push_ev(0);
      if (crej) push_ev(1);
      if (m_phase == 2) push_ev(2);
      if (m_phase == 3) push_ev(3);
    end
    s.busy = (m_phase != 0); s.dest = m_dest; s.qua = m_qua; s.cost = m_cost;
    s.coin = m_paid; s.refund = (m_phase == 3) ? m_paid : 0;
    stq.push_back(s);
  endtask

  task automatic cyc(input bit sel, input int dest, input int qua, input bit coin, input int val,
                     input bit cancel);
    @(negedge CLK);
    RD = rd_drv;
    SEL_VALID = sel; DEST_SEL = 2'(dest); QUA_SEL = 2'(qua);
    COIN_VALID = coin; COIN_VAL = 4'(val); CANCEL = cancel;
    model_step(rd_drv, sel, dest, qua, coin, val, cancel);
    started = 1'b1;
  endtask

  task automatic idle_cyc(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0);
  endtask
  task automatic sel_cyc(input int d, input int q);
    cyc(1, d, q, 0, 0, 0);
  endtask
  task automatic coin_cyc(input int v);
    cyc(0, 0, 0, 1, v, 0);
  endtask

  task automatic chk_pulse(input logic p, input int k);
    ev_t e;
    if (p) begin
      n_tests++;
      if (evq.size() == 0) begin
        n_fail++;
        $display("FAIL pulse_kind%0d: got unexpected pulse, required none at %0t", k, $time);
      end else begin
        e = evq.pop_front();
        if (e.kind != k ||
            (k == 2 && (DESTINATION_OUT != 2'(e.dest) || QUA_OUT != 2'(e.qua) ||
                        COST_OUT != 4'(e.cost) || COIN_OUT != 4'(e.coin))) ||
            (k == 3 && REFUND != 4'(e.refund))) begin
          n_fail++;
          $display("FAIL pulse_kind%0d: got kind %0d d=%0d q=%0d cost=%0d coin=%0d ref=%0d, %s",
                   k, k, DESTINATION_OUT, QUA_OUT, COST_OUT, COIN_OUT, REFUND, "required");
          $display("  required kind %0d d=%0d q=%0d cost=%0d coin=%0d ref=%0d at %0t",
                   e.kind, e.dest, e.qua, e.cost, e.coin, e.refund, $time);
        end
      end
    end
  endtask

  // Monitor: samples 1 time unit after each rising edge.
  always @(posedge CLK) begin : monitor
    st_t s;
    #1;
    if (started) begin
      chk_pulse(SEL_REJECT, 0);
      chk_pulse(COIN_REJECT, 1);
      chk_pulse(FINISH, 2);
      chk_pulse(REFUND_VALID, 3);
      n_tests++;
      if (evq.size() != 0) begin
        n_fail++;
        $display("FAIL missing_pulse: got no pulse, required kind %0d at %0t",
                 evq[0].kind, $time);
        evq.delete();
      end
      n_tests++;
      if (stq.size() == 0) begin
        n_fail++;
        $display("FAIL status: got a sample with no prediction at %0t", $time);
      end else begin
        s = stq.pop_front();
        if (BUSY != s.busy[0] || DESTINATION_OUT != 2'(s.dest) || QUA_OUT != 2'(s.qua) ||
            COST_OUT != 4'(s.cost) || COIN_OUT != 4'(s.coin) || REFUND != 4'(s.refund)) begin
          n_fail++;
          $display("FAIL status: got busy=%0d d=%0d q=%0d cost=%0d coin=%0d ref=%0d %s",
                   BUSY, DESTINATION_OUT, QUA_OUT, COST_OUT, COIN_OUT, REFUND, "required");
          $display("  busy=%0d d=%0d q=%0d cost=%0d coin=%0d ref=%0d at %0t",
                   s.busy, s.dest, s.qua, s.cost, s.coin, s.refund, $time);
        end
      end
    end
  end

  task automatic chk_all_zero(input string name);
    logic [23:0] v;
    v = {SEL_REJECT, COIN_REJECT, DESTINATION_OUT, QUA_OUT, COST_OUT, COIN_OUT, FINISH,
         REFUND, REFUND_VALID, BUSY};
    n_tests++;
    if (v != 24'd0) begin
      n_fail++;
      $display("FAIL %s: got outputs 0x%06h, required 0x000000", name, v);
    end
  endtask

  initial begin : stim
    int cp;
    bit sel, coin, cancel;
    int dest, qua, val;
    #1;
    chk_all_zero("reset_outputs");
    idle_cyc(2);
    rd_drv = 1'b1;
    idle_cyc(2);

    // Normal purchase, then a selection right after DONE.
    sel_cyc(1, 2); coin_cyc(5); coin_cyc(2); idle_cyc(1);
    sel_cyc(1, 1); coin_cyc(10); idle_cyc(2);
    // Rejected selections, then the maximum fare with an overflowing coin.
    sel_cyc(2, 3); idle_cyc(1); sel_cyc(0, 1); sel_cyc(1, 0); sel_cyc(3, 3);
    coin_cyc(10); coin_cyc(8); coin_cyc(0); coin_cyc(5); idle_cyc(2);
    // Coins while idle, cancel with a simultaneous coin, and a zero refund.
    coin_cyc(3);
    sel_cyc(2, 1); coin_cyc(4); cyc(0, 0, 0, 1, 2, 1); idle_cyc(2);
    sel_cyc(3, 1); cyc(0, 0, 0, 0, 0, 1); idle_cyc(2);
    // Timeout: coin restarts the count just before expiry, then the full timeout.
    sel_cyc(1, 2); coin_cyc(1); idle_cyc(TO - 1); coin_cyc(1); idle_cyc(TO + 3);
    // Rejected coins do not restart the count.
    sel_cyc(1, 1); idle_cyc(3); coin_cyc(0); idle_cyc(TO);

    // Asynchronous reset in the middle of a payment.
    sel_cyc(1, 2); coin_cyc(3); idle_cyc(1);
    @(posedge CLK);
    #3;
    RD = 1'b0;
    rd_drv = 1'b0;
    #1;
    chk_all_zero("async_reset");
    idle_cyc(2);
    rd_drv = 1'b1;
    idle_cyc(TO + 3);

    // Random traffic with varying coin density to exercise timeouts and overflow.
    for (int blk = 0; blk < 15; blk++) begin
      case (blk % 3)
        0: cp = 5;
        1: cp = 35;
        default: cp = 70;
      endcase
      for (int i = 0; i < 200; i++) begin
        sel = ($urandom_range(0, 99) < 25);
        dest = $urandom_range(0, 3);
        qua = $urandom_range(0, 3);
        coin = ($urandom_range(0, 99) < cp);
        val = $urandom_range(0, 1) ? $urandom_range(1, 6) : $urandom_range(0, 15);
        cancel = ($urandom_range(0, 99) < 3);
        cyc(sel, dest, qua, coin, val, cancel);
      end
    end
    idle_cyc(TO + 4);
    @(posedge CLK);
    #2;
    n_tests++;
    if (evq.size() != 0 || stq.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d events and %0d status left, required 0 and 0",
               evq.size(), stq.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fare_coin_collector.md
Name: fare_coin_collector

Overview:
- Upstream stage of change_processing. Latches the passenger's destination and quantity selection and computes the fare from a parameterised table.
- Accumulates inserted coins, then hands a stable {DESTINATION, QUA, COST, COIN} bundle with a one-cycle FINISH pulse to change_processing.
- Handles cancel and inactivity timeout by emitting a refund.

Parameters:
FARE1, 3, unit fare for destination 2'b01 (destination 2'b00 is invalid, fare 0)
FARE2, 6, unit fare for destination 2'b10
FARE3, 5, unit fare for destination 2'b11
TIMEOUT, 64, idle cycles in PAY before automatic cancel (>=2)

Ports:
CLK  in  1  system clock, rising edge
RD  in  1  reset; asynchronous, active-low
SEL_VALID  in  1  selection strobe
DEST_SEL  in  2  destination code
QUA_SEL  in  2  ticket quantity, 1..3
COIN_VALID  in  1  coin strobe, one coin per asserted cycle
COIN_VAL  in  4  coin value
CANCEL  in  1  passenger cancel request
SEL_REJECT  out  1  one-cycle pulse: selection refused
COIN_REJECT  out  1  one-cycle pulse: coin refused (return to passenger)
DESTINATION_OUT  out  2  latched destination, to change_processing DESTINATION_IN
QUA_OUT  out  2  latched quantity, to QUA_IN
COST_OUT  out  4  latched total fare, to COST_IN
COIN_OUT  out  4  accumulated payment, to COIN_IN
FINISH  out  1  one-cycle pulse: bundle valid, to change_processing FINISH
REFUND  out  4  refund amount, valid with REFUND_VALID
REFUND_VALID  out  1  one-cycle refund pulse
BUSY  out  1  high in every state except IDLE

Behaviour:
- Reset (RD=0, async): state IDLE. All outputs are 0, and the accumulator and timeout counter are 0. Release is synchronous to the next CLK edge.
- All outputs are registered. FINISH, SEL_REJECT, COIN_REJECT and REFUND_VALID are exactly one cycle wide.
- States: IDLE, PAY, DONE, REFUND.
- IDLE, SEL_VALID=1:
  - cost = fare(DEST_SEL) * QUA_SEL, computed at 6 bits.
  - Reject if DEST_SEL=0, QUA_SEL=0, or cost>15. On reject: SEL_REJECT pulses next cycle and state stays IDLE.
  - Otherwise: DESTINATION_OUT, QUA_OUT and COST_OUT are latched, COIN_OUT is cleared to 0, and the state moves to PAY on the same edge.
- IDLE: COIN_VALID triggers a COIN_REJECT pulse; CANCEL is ignored.
- PAY, accepting a coin (COIN_VALID=1, CANCEL=0):
  - Coin is accepted if COIN_VAL!=0 and COIN_OUT+COIN_VAL<=15 (5-bit compare). Then COIN_OUT becomes COIN_OUT+COIN_VAL and the timeout counter clears.
  - COIN_VAL=0 or overflow: the coin is rejected (COIN_REJECT pulse), COIN_OUT is unchanged, and the counter is not cleared.
- PAY, payment complete: when the post-update sum >= COST_OUT, move to DONE. Test on the new value, so the move happens on the same edge as the accepting coin.
- PAY, cancel/timeout:
  - CANCEL=1 moves to REFUND. If COIN_VALID=1 in the same cycle, cancel wins and that coin is rejected.
  - The timeout counter increments on each PAY cycle without an accepted coin. At count TIMEOUT-1 the state moves to REFUND as if CANCEL were asserted.
- PAY: SEL_VALID is ignored.
- DONE (one cycle):
  - FINISH=1. DESTINATION_OUT, QUA_OUT, COST_OUT and COIN_OUT are stable.
  - CANCEL and COIN_VALID are ignored; a coin here triggers COIN_REJECT.
  - Next state is IDLE.
  - The bundle holds its value until the next accepted selection, since change_processing samples it on FINISH.
- REFUND (one cycle):
  - REFUND_VALID=1 with REFUND=COIN_OUT.
  - Next state is IDLE. COIN_OUT, COST_OUT, DESTINATION_OUT and QUA_OUT are cleared to 0, and REFUND returns to 0 one cycle later.
  - FINISH is not asserted.
- A refund of 0 (cancel before any coin) still pulses REFUND_VALID.
- Reset asserted mid-transaction: immediate IDLE with all outputs 0. No FINISH, no refund pulse.
- Overpayment is passed through as-is (COIN_OUT>COST_OUT); change_processing computes change.
- A new selection in the cycle right after DONE/REFUND (now IDLE) is accepted normally.

Test Plan:
- Reset then SEL dest=01 qua=2 → COST_OUT=6, BUSY=1. Coins 5, 2 → COIN_OUT 5 then 7. FINISH pulses the cycle after the 2-coin is accepted, with DESTINATION_OUT=01, QUA_OUT=2, COST_OUT=6, COIN_OUT=7.
- SEL dest=10 qua=3 (18>15) → SEL_REJECT pulse, BUSY=0. SEL dest=00 qua=1 → SEL_REJECT. SEL dest=11 qua=3 → COST_OUT=15 accepted.
- With COST_OUT=15: coins 10, then 8 → COIN_REJECT, COIN_OUT stays 10. Coin 5 → COIN_OUT=15, FINISH.
- SEL dest=10 qua=1 (cost 6), coin 4, then CANCEL and COIN_VALID=1 (val 2) in the same cycle → COIN_REJECT, REFUND_VALID with REFUND=4, no FINISH, outputs cleared.
- TIMEOUT=8: select, coin 1, then 7 idle cycles → REFUND_VALID with REFUND=1 on the cycle after the counter reaches 7. A coin inserted just before expiry restarts the count.
- Mid-PAY with COIN_OUT=3, drive RD=0 between clock edges → all outputs 0 immediately, state IDLE, no REFUND_VALID or FINISH after release.
